// File: rtl/schnorr_challenge_pkg.sv
// -----------------------------------------------------------------------------
// schnorr_pkg
// Shared constants for the Schnorr challenge block:
//   - default challenge width and group order
//   - SHA-256 block / digest widths and their vector types
//   - FSM state encoding
//   - pad_len(): bit length of the hashed message (R || msg), as placed in the
//     trailing 64-bit length field of the padded block
// -----------------------------------------------------------------------------
package schnorr_pkg;

   localparam int          LEN_DEFAULT = 32;
   localparam logic [31:0] Q_DEFAULT   = 32'hFFFF_FFFB;

   localparam int SHA_BLK_W = 512;
   localparam int SHA_DIG_W = 256;
   localparam int MSG_W     = 32;
   localparam int LEN_W     = 64;

   typedef logic [SHA_BLK_W-1:0] sha_block_t;
   typedef logic [SHA_DIG_W-1:0] sha_digest_t;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_PACK  = 3'd1;
   localparam logic [2:0] ST_HREQ  = 3'd2;
   localparam logic [2:0] ST_HWAIT = 3'd3;
   localparam logic [2:0] ST_RED   = 3'd4;
   localparam logic [2:0] ST_DONE  = 3'd5;

   // Message length in bits for an R of width len followed by one msg word.
   function automatic logic [LEN_W-1:0] pad_len(input int len);
      return LEN_W'(len + MSG_W);
   endfunction

endpackage

// File: rtl/schnorr_challenge_if.sv
// -----------------------------------------------------------------------------
// schnorr_challenge_if
// Connection to an external single-block SHA-256 core.
//   sha_start  : one-cycle request pulse (challenge -> core)
//   sha_block  : padded 512-bit block, stable while the core works
//   sha_done   : one-cycle completion pulse (core -> challenge)
//   sha_digest : 256-bit digest, valid in the sha_done cycle
// master = challenge side, slave = SHA core side.
// -----------------------------------------------------------------------------
interface schnorr_challenge_if;
   import schnorr_pkg::*;

   logic        sha_start;
   sha_block_t  sha_block;
   logic        sha_done;
   sha_digest_t sha_digest;

   modport master (
      output sha_start,
      output sha_block,
      input  sha_done,
      input  sha_digest
   );

   modport slave (
      input  sha_start,
      input  sha_block,
      output sha_done,
      output sha_digest
   );

endinterface

// File: rtl/schnorr_challenge_mod_reduce_serial.sv
// -----------------------------------------------------------------------------
// mod_reduce_serial
// Bit-serial reduction of an N-bit value modulo Q, MSB first, one bit per
// cycle (exactly N step cycles after load).
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : latch din, clear remainder, start stepping next cycle
//   din        : value to reduce
//   busy       : high while steps remain
//   done       : high during the cycle that performs the final step;
//                rem holds the finished result from the following cycle on
//   rem        : current remainder (always < Q)
// -----------------------------------------------------------------------------
module mod_reduce_serial #(
   parameter int             LEN = 32,
   parameter logic [LEN-1:0] Q   = LEN'(32'hFFFF_FFFB),
   parameter int             N   = 256
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           load,
   input  logic [N-1:0]   din,
   output logic           busy,
   output logic           done,
   output logic [LEN-1:0] rem
);

   localparam int           CW    = $clog2(N);
   localparam logic [LEN:0] Q_EXT = {1'b0, Q};

   logic [N-1:0]  shift_reg;
   logic [LEN:0]  rem_reg;
   logic [CW-1:0] cnt_reg;
   logic          busy_reg;

   logic [LEN:0]  t;
   logic [LEN:0]  rem_next;

   // r < Q, so 2r+bit < 2Q and a single conditional subtract brings it back
   // below Q. The shift keeps LEN+1 bits, which is enough for 2r+bit.
   always_comb begin
      t        = (rem_reg << 1) | {{LEN{1'b0}}, shift_reg[N-1]};
      rem_next = (t >= Q_EXT) ? (t - Q_EXT) : t;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_reg <= '0;
         rem_reg   <= '0;
         cnt_reg   <= '0;
         busy_reg  <= 1'b0;
      end else if (load) begin
         shift_reg <= din;
         rem_reg   <= '0;
         cnt_reg   <= CW'(N - 1);
         busy_reg  <= 1'b1;
      end else if (busy_reg) begin
         shift_reg <= shift_reg << 1;
         rem_reg   <= rem_next;
         cnt_reg   <= cnt_reg - CW'(1);
         // The count-0 step still executes; it is the last one.
         if (cnt_reg == '0) begin
            busy_reg <= 1'b0;
         end
      end
   end

   assign busy = busy_reg;
   assign done = busy_reg && (cnt_reg == '0);
   assign rem  = rem_reg[LEN-1:0];

endmodule

// File: rtl/schnorr_challenge.sv
// -----------------------------------------------------------------------------
// schnorr_challenge
// Computes c = SHA-256(R || msg) mod Q using an external SHA-256 core.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   start      : request, sampled only while idle
//   R_in, msg  : nonce R (LEN bits) and message word (32 bits)
//   busy       : high in every state except IDLE
//   done       : one-cycle pulse, coincident with the c_out update
//   c_out      : challenge, held until the next done
//   sha        : master side of the SHA-core start/done interface
// Sequence: IDLE -> PACK -> HREQ -> HWAIT -> RED (256 cycles) -> DONE -> IDLE.
// -----------------------------------------------------------------------------
module schnorr_challenge
   import schnorr_pkg::*;
#(
   parameter int             LEN = LEN_DEFAULT,
   parameter logic [LEN-1:0] Q   = LEN'(Q_DEFAULT)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [LEN-1:0]      R_in,
   input  logic [MSG_W-1:0]    msg,
   output logic                busy,
   output logic                done,
   output logic [LEN-1:0]      c_out,
   schnorr_challenge_if.master sha
);

   // Bit position of the least significant msg bit inside the block.
   localparam int MSG_LSB = SHA_BLK_W - LEN - MSG_W;

   logic [2:0]       state_reg;
   logic [2:0]       state_next;
   logic [LEN-1:0]   r_reg;
   logic [MSG_W-1:0] msg_reg;
   sha_block_t       block_reg;
   sha_block_t       block_next;
   logic [LEN-1:0]   c_reg;
   logic             done_reg;

   logic             red_load;
   logic             red_busy;
   logic             red_done;
   logic [LEN-1:0]   red_rem;

   // Single padded block: R || msg || 1 || zeros || 64-bit length.
   always_comb begin
      block_next                         = '0;
      block_next[SHA_BLK_W-1 -: LEN]     = r_reg;
      block_next[MSG_LSB +: MSG_W]       = msg_reg;
      block_next[MSG_LSB-1]              = 1'b1;
      block_next[LEN_W-1:0]              = pad_len(LEN);
   end

   always_comb begin
      state_next = state_reg;
      red_load   = 1'b0;
      case (state_reg)
         ST_IDLE:  if (start) state_next = ST_PACK;
         ST_PACK:  state_next = ST_HREQ;
         ST_HREQ:  state_next = ST_HWAIT;
         ST_HWAIT: begin
            // sha_done is only honoured here; elsewhere it is ignored.
            if (sha.sha_done) begin
               state_next = ST_RED;
               red_load   = 1'b1;
            end
         end
         ST_RED:   if (red_done) state_next = ST_DONE;
         ST_DONE:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         r_reg     <= '0;
         msg_reg   <= '0;
         block_reg <= '0;
         c_reg     <= '0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         done_reg  <= 1'b0;
         if (state_reg == ST_IDLE && start) begin
            r_reg   <= R_in;
            msg_reg <= msg;
         end
         if (state_reg == ST_PACK) begin
            block_reg <= block_next;
         end
         if (state_reg == ST_DONE) begin
            c_reg    <= red_rem;
            done_reg <= 1'b1;
         end
      end
   end

   mod_reduce_serial #(
      .LEN (LEN),
      .Q   (Q),
      .N   (SHA_DIG_W)
   ) u_reduce (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (red_load),
      .din   (sha.sha_digest),
      .busy  (red_busy),
      .done  (red_done),
      .rem   (red_rem)
   );

   assign sha.sha_start = (state_reg == ST_HREQ);
   assign sha.sha_block = block_reg;
   assign busy          = (state_reg != ST_IDLE) || red_busy;
   assign done          = done_reg;
   assign c_out         = c_reg;

endmodule

// File: doc/schnorr_challenge.md
Name: schnorr_challenge

Overview:
Computes the Schnorr challenge c = SHA-256(R || msg) mod q. It feeds the challenge into the signer (SIGNGEN_CHALL) and the verifier (VERIFY_CHALL) in place of the fixed challenge constant.
- Builds one padded 512-bit SHA-256 block from R and msg.
- Drives an external single-block SHA-256 core over a start/done handshake.
- Reduces the 256-bit digest modulo q with a bit-serial shift-subtract reducer.

Parameters:
LEN, 32, width of R, q and c; legal range 2..415 so that R, msg, pad bit and 64-bit length fit one block.
Q, 32'hFFFFFFFB, group order q; must satisfy 2 <= Q < 2^LEN.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle request; sampled only in IDLE.
R_in  in  LEN  public nonce R.
msg  in  32  message word.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse when c_out is updated.
c_out  out  LEN  challenge; held until the next done.
sha_start  out  1  one-cycle pulse to the SHA core.
sha_block  out  512  padded block; stable from PACK until the next start.
sha_done  in  1  SHA core completion pulse.
sha_digest  in  256  digest; valid in the sha_done cycle.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, c_out=0, sha_start=0, sha_block=0, internal remainder and counter=0.
  - Reset mid-operation aborts immediately. No partial c_out is ever published.
  - A sha_done arriving after reset is ignored.
- States and dwell times:
  - IDLE: waits for start=1. On start, latch R_in and msg, go to PACK.
  - PACK (1 cycle): sha_block <= {R, msg, 1'b1, zeros, 64-bit length}. Length = LEN+32. Go to HREQ.
  - HREQ (1 cycle): sha_start=1. Go to HWAIT.
  - HWAIT: waits for sha_done=1. A sha_done in the same cycle as HREQ is not possible by the core contract and is not handled. On sha_done, latch sha_digest into the shift register, clear the remainder, set counter=255, go to RED.
  - RED (exactly 256 cycles): one digest bit per cycle, MSB first.
    - t = 2*r + bit, computed LEN+1 bits wide.
    - r <= (t >= Q) ? t - Q : t.
    - One conditional subtract suffices because r < Q.
    - When counter=0 the step still executes, then go to DONE.
  - DONE (1 cycle): c_out <= r; done=1; go to IDLE.
- Handshake rules:
  - done and c_out update on the same edge.
  - busy is 0 in the cycle after DONE, where a new start is accepted.
  - start while busy is ignored, with no queuing.
  - sha_done outside HWAIT is ignored.
- Latency: if sha_done is high k cycles after the sha_start cycle, done rises k+259 cycles after the start sample edge.
- Width rules:
  - The remainder register is LEN+1 bits; c_out takes the low LEN bits.
  - The comparison is unsigned.
  - The result always satisfies c_out < Q.

Decomposition:
- Package schnorr_pkg holds:
  - LEN and Q defaults;
  - SHA_BLK_W=512 and SHA_DIG_W=256;
  - state encoding as localparams;
  - a padding-length constant function.
- One natural sub-module: mod_reduce_serial (parameters LEN, Q, N=256), with its own load/busy/done and bit-serial remainder. schnorr_challenge instantiates it and contains only the FSM and block packing.

Test Plan:
- Reset mid-RED: assert rst_n=0 after 100 RED cycles -> all outputs 0, state IDLE. Then a new start completes normally, with done exactly once.
- Reduction, small modulus: Q=13, LEN=8, bench SHA model returns digest=256'd100 with k=3 -> done at start+262, c_out=9, c_out<13.
- Reduction, wrap-heavy: Q=32'hFFFFFFFB, digest=all ones -> c_out=390624, because 2^256 mod q = 5^8.
- Packing: LEN=32, R_in=32'hDEADBEEF, msg=32'h00000001 -> sha_block[511:448]=64'hDEADBEEF00000001, bit 447=1, bits [63:0]=64'd64, all other bits 0. Real SHA core gives c_out = SHA256(block) mod q, matched against a software golden value.
- Handshake: pulse start during HWAIT and again during RED -> ignored; no second sha_start.
  - Then start in the first cycle busy=0 -> accepted.
  - A spurious sha_done while in RED -> no effect.
- Back-to-back: two requests with different R, each started in the first IDLE cycle -> two done pulses, each c_out correct, and c_out held constant between done pulses.
